// File: rtl/matrix_result_collector.sv
// Matrix result collector: captures M x N result elements arriving in any
// order from a matrix multiplier, checks them for completeness, duplicates
// and out-of-range indices, then drains them in row-major order over a
// valid/ready stream.
module matrix_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int M          = 4,
    parameter int N          = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic signed [DATA_WIDTH-1:0]                  c_data,
    input  logic        [((M > 1) ? $clog2(M) : 1)-1:0]   c_row,
    input  logic        [((N > 1) ? $clog2(N) : 1)-1:0]   c_col,
    input  logic                                          c_valid,
    input  logic                                          done,
    output logic signed [DATA_WIDTH-1:0]                  out_data,
    output logic        [((M > 1) ? $clog2(M) : 1)-1:0]   out_row,
    output logic        [((N > 1) ? $clog2(N) : 1)-1:0]   out_col,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_last,
    output logic                                          busy,
    output logic                                          complete,
    output logic                                          err_missing,
    output logic                                          err_dup,
    output logic                                          err_range
);

    localparam int RW    = (M > 1) ? $clog2(M) : 1;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int TOTAL = M * N;
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(TOTAL - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic [RW:0]   ROW_LIM  = (RW + 1)'(M);
    localparam logic [CW:0]   COL_LIM  = (CW + 1)'(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    // FRAC_WIDTH is format metadata for downstream consumers; elements are
    // stored and replayed bit-exact, so the collector never interprets it.
    if (FRAC_WIDTH > DATA_WIDTH) begin : g_frac_exceeds_data
    end

    logic [1:0]                   state;
    logic [TOTAL-1:0]             written;
    logic signed [DATA_WIDTH-1:0] buffer [TOTAL];
    logic [IW-1:0]                idx;
    logic [RW-1:0]                row;
    logic [CW-1:0]                col;

    logic                         in_range;
    logic [IW-1:0]                wr_idx;
    logic                         wr_en;
    logic [TOTAL-1:0]             written_next;
    logic                         all_written;
    logic                         xfer;
    logic                         is_last;

    // Decode the incoming element: range check, flat index, and the bitmap as
    // it will look including this cycle's write (so done sees it too).
    always_comb begin
        in_range     = ({1'b0, c_row} < ROW_LIM) && ({1'b0, c_col} < COL_LIM);
        wr_idx       = IW'(int'(c_row) * N + int'(c_col));
        wr_en        = (state == S_CAPTURE) && c_valid && in_range;
        written_next = written;
        if (wr_en) begin
            written_next = written | (TOTAL'(1) << wr_idx);
        end
        all_written  = &written_next;
        xfer         = (state == S_DRAIN) && out_ready;
        is_last      = (idx == IDX_LAST);
    end

    // Control path: FSM, written-flag bitmap, drain index and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            written     <= '0;
            idx         <= '0;
            row         <= '0;
            col         <= '0;
            complete    <= 1'b0;
            err_missing <= 1'b0;
            err_dup     <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            complete <= 1'b0;
            if (start) begin
                state       <= S_CAPTURE;
                written     <= '0;
                idx         <= '0;
                row         <= '0;
                col         <= '0;
                err_missing <= 1'b0;
                err_dup     <= 1'b0;
                err_range   <= 1'b0;
            end else begin
                unique case (state)
                    S_CAPTURE: begin
                        written <= written_next;
                        if (wr_en && written[wr_idx]) begin
                            err_dup <= 1'b1;
                        end
                        if (c_valid && !in_range) begin
                            err_range <= 1'b1;
                        end
                        if (done) begin
                            idx <= '0;
                            row <= '0;
                            col <= '0;
                            if (all_written) begin
                                state <= S_DRAIN;
                            end else begin
                                err_missing <= 1'b1;
                                state       <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (xfer) begin
                            if (is_last) begin
                                state    <= S_IDLE;
                                complete <= 1'b1;
                                idx      <= '0;
                                row      <= '0;
                                col      <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                                if (col == COL_LAST) begin
                                    col <= '0;
                                    row <= row + 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Element storage: plain write port, last write to an index wins.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_idx] <= c_data;
        end
    end

    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = out_valid && is_last;
    assign out_data  = out_valid ? buffer[idx] : '0;
    assign out_row   = out_valid ? row : '0;
    assign out_col   = out_valid ? col : '0;

endmodule

// File: tb/tb_matrix_result_collector.sv
// Scoreboard bench for matrix_result_collector: directed captures push the
// expected row-major drain into a queue, monitors pop and compare on every
// presented element. A second 3x3 instance covers range errors and
// non-power-of-two index wrap.
`timescale 1ns/1ps
module tb_matrix_result_collector;

    typedef struct {
        logic signed [15:0] data;
        int                 row;
        int                 col;
        bit                 last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, c_valid, done, out_ready;
    logic signed [15:0] c_data;
    logic [1:0]         c_row;
    logic [0:0]         c_col;
    logic signed [15:0] out_data;
    logic [1:0]         out_row;
    logic [0:0]         out_col;
    logic out_valid, out_last, busy, complete, err_missing, err_dup, err_range;

    logic               t_start, t_c_valid, t_done, t_out_ready;
    logic signed [15:0] t_c_data;
    logic [1:0]         t_c_row, t_c_col;
    logic signed [15:0] t_out_data;
    logic [1:0]         t_out_row, t_out_col;
    logic t_out_valid, t_out_last, t_busy, t_complete, t_err_missing, t_err_dup, t_err_range;

    matrix_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .c_data(c_data), .c_row(c_row),
        .c_col(c_col), .c_valid(c_valid), .done(done), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .complete(complete), .err_missing(err_missing), .err_dup(err_dup),
        .err_range(err_range)
    );

    matrix_result_collector #(.M(3), .N(3)) dut3 (
        .clk(clk), .rst(rst), .start(t_start), .c_data(t_c_data), .c_row(t_c_row),
        .c_col(t_c_col), .c_valid(t_c_valid), .done(t_done), .out_data(t_out_data),
        .out_row(t_out_row), .out_col(t_out_col), .out_valid(t_out_valid),
        .out_ready(t_out_ready), .out_last(t_out_last), .busy(t_busy),
        .complete(t_complete), .err_missing(t_err_missing), .err_dup(t_err_dup),
        .err_range(t_err_range)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t q3[$];
    int   cmpl_cnt = 0;
    int   cmpl3_cnt = 0;
    bit   exp_cmpl = 0;
    bit   exp_cmpl3 = 0;
    logic signed [15:0] mat [4][2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the 4x2 instance
    always @(negedge clk) begin
        if (complete) cmpl_cnt++;
        if (exp_cmpl) begin
            chk("complete_pulse", complete, 1);
            exp_cmpl = 0;
        end else if (complete) begin
            chk("complete_unexpected", complete, 0);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("out_valid_unexpected", out_valid, 0);
            end else begin
                chk("out_data", out_data, q[0].data);
                chk("out_row", out_row, q[0].row);
                chk("out_col", out_col, q[0].col);
                chk("out_last", out_last, q[0].last);
                if (out_ready) begin
                    if (q[0].last) exp_cmpl = 1;
                    void'(q.pop_front());
                end
            end
        end
    end

    // Monitor for the 3x3 instance
    always @(negedge clk) begin
        if (t_complete) cmpl3_cnt++;
        if (exp_cmpl3) begin
            chk("t_complete_pulse", t_complete, 1);
            exp_cmpl3 = 0;
        end else if (t_complete) begin
            chk("t_complete_unexpected", t_complete, 0);
        end
        if (t_out_valid) begin
            if (q3.size() == 0) begin
                chk("t_out_valid_unexpected", t_out_valid, 0);
            end else begin
                chk("t_out_data", t_out_data, q3[0].data);
                chk("t_out_row", t_out_row, q3[0].row);
                chk("t_out_col", t_out_col, q3[0].col);
                chk("t_out_last", t_out_last, q3[0].last);
                if (t_out_ready) begin
                    if (q3[0].last) exp_cmpl3 = 1;
                    void'(q3.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int r, input int c, input logic signed [15:0] d, input bit with_done = 0);
        c_valid = 1'b1;
        c_row   = r[1:0];
        c_col   = c[0:0];
        c_data  = d;
        done    = with_done;
        tick();
        c_valid = 1'b0;
        done    = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // Writes the matrix in a scrambled order, optionally leaving one index out
    task automatic write_all(input int skip);
        int ord[8] = '{5, 2, 7, 0, 3, 6, 1, 4};
        for (int k = 0; k < 8; k++) begin
            if (ord[k] != skip) wr(ord[k] / 2, ord[k] % 2, mat[ord[k] / 2][ord[k] % 2]);
        end
    endtask

    task automatic push_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 2; c++)
                q.push_back('{mat[r][c], r, c, (r == 3 && c == 1)});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, (n < 200), 1);
    endtask

    task automatic chk_errs(input string name, input bit m, input bit d, input bit r);
        chk({name, "_err_missing"}, err_missing, m);
        chk({name, "_err_dup"}, err_dup, d);
        chk({name, "_err_range"}, err_range, r);
    endtask

    task automatic t_wr(input int r, input int c, input logic signed [15:0] d);
        t_c_valid = 1'b1;
        t_c_row   = r[1:0];
        t_c_col   = c[1:0];
        t_c_data  = d;
        tick();
        t_c_valid = 1'b0;
    endtask

    initial begin
        int n;
        bit pat[4] = '{1, 0, 0, 1};

        rst = 1'b1; start = 1'b0; c_valid = 1'b0; done = 1'b0; out_ready = 1'b1;
        c_data = '0; c_row = '0; c_col = '0;
        t_start = 1'b0; t_c_valid = 1'b0; t_done = 1'b0; t_out_ready = 1'b1;
        t_c_data = '0; t_c_row = '0; t_c_col = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_complete", complete, 0);
        chk_errs("rst", 0, 0, 0);
        rst = 1'b0;
        tick();

        // Full capture, scrambled order, continuous drain
        mat = '{'{16'sh0400, 16'sh0500}, '{16'sh0A00, 16'sh0B00},
                '{16'sh1000, 16'sh1100}, '{16'sh0300, 16'sh0200}};
        do_start();
        chk("cap_busy", busy, 1);
        write_all(-1);
        push_all();
        pulse_done();
        chk("drain_first_valid", out_valid, 1);
        chk("drain_first_data", out_data, 16'sh0400);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("drain_cycles", n, 8);
        chk("drain_queue_empty", q.size(), 0);
        tick();
        chk("full_complete_cnt", cmpl_cnt, 1);
        chk_errs("full", 0, 0, 0);

        // Backpressure with ready pattern 1,0,0,1
        mat = '{'{16'shFE80, 16'sh0080}, '{16'sh7FFF, 16'sh8000},
                '{16'sh0001, 16'shFFFF}, '{16'sh1234, 16'shC000}};
        do_start();
        write_all(-1);
        push_all();
        pulse_done();
        n = 0;
        while ((busy || q.size() != 0) && n < 100) begin
            out_ready = pat[n % 4];
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk("bp_timeout", (n < 100), 1);
        chk("bp_queue_empty", q.size(), 0);
        tick();
        chk("bp_complete_cnt", cmpl_cnt, 2);

        // Missing element (2,1)
        mat = '{'{16'sh0400, 16'sh0500}, '{16'sh0A00, 16'sh0B00},
                '{16'sh1000, 16'sh1100}, '{16'sh0300, 16'sh0200}};
        do_start();
        write_all(5);
        pulse_done();
        chk_errs("missing", 1, 0, 0);
        chk("missing_busy", busy, 0);
        chk("missing_out_valid", out_valid, 0);
        repeat (5) tick();
        chk("missing_complete_cnt", cmpl_cnt, 2);

        // Duplicate write to (0,0): 0x0100 then 0x0400
        do_start();
        chk("start_clears_missing", err_missing, 0);
        wr(0, 0, 16'sh0100);
        write_all(-1);
        push_all();
        pulse_done();
        chk_errs("dup", 0, 1, 0);
        wait_idle("dup");
        tick();
        chk("dup_complete_cnt", cmpl_cnt, 3);
        chk("dup_sticky", err_dup, 1);

        // Last element arrives together with done
        do_start();
        chk("start_clears_dup", err_dup, 0);
        write_all(7);
        push_all();
        wr(3, 1, mat[3][1], 1);
        chk("samecycle_drain", out_valid, 1);
        wait_idle("samecycle");
        tick();
        chk("samecycle_complete_cnt", cmpl_cnt, 4);
        chk_errs("samecycle", 0, 0, 0);

        // Abort after the third transfer, then a fresh capture
        do_start();
        write_all(-1);
        push_all();
        pulse_done();
        repeat (3) tick();
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 1);
        chk("abort_transfers", q.size(), 5);
        q.delete();
        out_ready = 1'b1;
        mat = '{'{16'sh0111, 16'sh0222}, '{16'sh0333, 16'sh0444},
                '{16'sh0555, 16'sh0666}, '{16'sh0777, 16'sh0888}};
        write_all(-1);
        push_all();
        pulse_done();
        wait_idle("fresh");
        tick();
        chk("abort_complete_cnt", cmpl_cnt, 5);
        chk_errs("fresh", 0, 0, 0);

        // Reset mid-capture with a pending duplicate error
        do_start();
        wr(0, 0, 16'sh0101);
        wr(0, 0, 16'sh0202);
        wr(1, 1, 16'sh0303);
        chk("pre_rst_dup", err_dup, 1);
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_complete", complete, 0);
        chk_errs("midrst", 0, 0, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_complete_cnt", cmpl_cnt, 5);

        // 3x3 instance: out-of-range writes and non-power-of-two wrap
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        for (int r = 2; r >= 0; r--) begin
            for (int c = 0; c < 3; c++) begin
                t_wr(r, c, 16'((r * 3 + c + 1) * 256));
                if (r == 1 && c == 1) t_wr(3, 0, 16'sh7777);
            end
        end
        t_wr(0, 3, 16'sh6666);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                q3.push_back('{16'((r * 3 + c + 1) * 256), r, c, (r == 2 && c == 2)});
        t_done = 1'b1;
        tick();
        t_done = 1'b0;
        chk("t_err_range", t_err_range, 1);
        chk("t_err_dup", t_err_dup, 0);
        chk("t_err_missing", t_err_missing, 0);
        n = 0;
        while (t_busy && n < 50) begin
            tick();
            n++;
        end
        chk("t_drain_cycles", n, 9);
        chk("t_queue_empty", q3.size(), 0);
        tick();
        chk("t_complete_cnt", cmpl3_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
